fetch_pc_ifid: RTL
==================

// Module: fetch_pc_ifid
// PURPOSE
//  Fetch-stage sequencer. Owns the program counter, drives the instruction
//  memory address, and captures {pc, instruction} into the IF/ID register.
//  The instruction memory itself is asynchronous-read and lives outside this block.
//  Also handles stall, branch redirect/flush and a HALT state.
// PARAMETERS
//  PC_WIDTH     8             PC / imem address width (256-word imem)
//  INSTR_WIDTH  32            instruction width
//  RESET_PC     0             PC value loaded on reset
//  HALT_INSTR   32'hFFFFFFFF  encoding that stops sequential fetch
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            asynchronous active-low reset
//  stall          in   1            hazard stall from decode: hold PC and IF/ID
//  branch_taken   in   1            redirect request from a later stage
//  branch_target  in   PC_WIDTH     redirect address
//  imem_addr      out  PC_WIDTH     = pc_q (combinational), to instruction memory
//  imem_instr     in   INSTR_WIDTH  instruction at imem_addr, same cycle
//  ifid_valid     out  1            IF/ID holds a real instruction
//  ifid_pc        out  PC_WIDTH     PC of the IF/ID instruction
//  ifid_pc_plus1  out  PC_WIDTH     ifid_pc + 1, mod 2^PC_WIDTH
//  ifid_instr     out  INSTR_WIDTH  latched instruction
//  halted         out  1            FSM is in HALTED
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately, no clock needed): pc_q=RESET_PC,
//   state=RUN, ifid_valid=0, ifid_pc=0, ifid_pc_plus1=0, ifid_instr=0, halted=0.
//  Latency: the instruction at pc_q appears on ifid_* one clock edge later.
//  States are RUN and HALTED. At each rising edge, apply the first rule that matches:
//   1 branch_taken (any state, overrides stall): pc_q<=branch_target,
//     ifid_valid<=0 (flush), state<=RUN. ifid_pc/instr may keep old values.
//   2 stall: pc_q, all ifid_* and state hold.
//   3 RUN and imem_instr==HALT_INSTR: IF/ID loads {pc_q, imem_instr} with valid=1;
//     pc_q holds; state<=HALTED.
//   4 RUN otherwise: IF/ID loads {pc_q, pc_q+1, imem_instr} with valid=1;
//     pc_q<=pc_q+1.
//   5 HALTED: pc_q holds; ifid_valid<=0. Only branch_taken or reset exits HALTED.
//  Arithmetic: PC increment wraps modulo 2^PC_WIDTH (0xFF -> 0x00). There is no
//   overflow flag.
//  halted = (state==HALTED), registered.
//  imem_addr always equals pc_q, including during stall and HALTED.
//  Back-to-back branch_taken cycles: each edge loads the newest target, and
//   ifid_valid stays 0.
//  X on stall or branch_taken while rst_n=0 must not corrupt the reset values.
// TESTING
//  T1 Release reset; imem[a]=32'h100+a; no stall or branch -> 1st edge: ifid_valid=1,
//     ifid_pc=0, ifid_instr=0x100; 2nd edge: ifid_pc=1, ifid_instr=0x101; imem_addr=2.
//  T2 Assert stall for 2 cycles while imem_addr=5 -> imem_addr stays 5; ifid_pc stays 4
//     with valid=1; after stall drops, the next edge gives ifid_pc=5.
//  T3 At imem_addr=7, assert branch_taken=1 with target 0x40 and stall=1 together ->
//     imem_addr=0x40, ifid_valid=0; next edge: ifid_pc=0x40, valid=1.
//  T4 Branch to 0xFE, then run 3 edges -> ifid_pc goes 0xFE, 0xFF, 0x00;
//     ifid_pc_plus1=0x00 while ifid_pc=0xFF; imem_addr=0x01.
//  T5 imem[0x10]=HALT_INSTR -> IF/ID={0x10, HALT_INSTR}, valid=1, halted=1; then
//     valid=0 and imem_addr=0x10 for 5 cycles; branch_taken to 0x20 -> halted=0,
//     and on the next edge ifid_pc=0x20.
//  T6 Pull rst_n low mid-run between clock edges -> all outputs take reset values
//     immediately; after release, the sequence restarts at ifid_pc=0.

Source files
------------

// File: rtl/fetch_pc_ifid_if.sv
// Fetch-stage bus: redirect/stall controls in,
// imem address out, IF/ID bundle out.
interface fetch_pc_ifid_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
) ();

  logic                   stall;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic                   ifid_valid;
  logic [PC_WIDTH-1:0]    ifid_pc;
  logic [PC_WIDTH-1:0]    ifid_pc_plus1;
  logic [INSTR_WIDTH-1:0] ifid_instr;
  logic                   halted;

  modport master (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  imem_instr,
    output imem_addr,
    output ifid_valid,
    output ifid_pc,
    output ifid_pc_plus1,
    output ifid_instr,
    output halted
  );

  modport slave (
    output stall,
    output branch_taken,
    output branch_target,
    output imem_instr,
    input  imem_addr,
    input  ifid_valid,
    input  ifid_pc,
    input  ifid_pc_plus1,
    input  ifid_instr,
    input  halted
  );

endinterface

// File: rtl/fetch_pc_ifid.sv
// Fetch-stage sequencer: owns the PC, addresses imem,
// fills IF/ID, handles stall, redirect and HALT.
module fetch_pc_ifid #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_pc_ifid_if.master       bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pc_plus1;
    logic [INSTR_WIDTH-1:0] instr;
  } if_id_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next_seq;
  if_id_t              ifid_q;

  logic is_halt;
  logic do_redirect;
  logic do_hold;
  logic do_halt;
  logic do_step;
  logic do_idle;

  assign pc_next_seq = pc_q + 1'b1;
  assign is_halt     = (bus.imem_instr == HALT_INSTR);

  // One-hot rule select: redirect beats stall beats state.
  always_comb begin
    do_redirect = 1'b0;
    do_hold     = 1'b0;
    do_halt     = 1'b0;
    do_step     = 1'b0;
    do_idle     = 1'b0;
    if (bus.branch_taken)
      do_redirect = 1'b1;
    else if (bus.stall)
      do_hold = 1'b1;
    else if (state_q == HALTED)
      do_idle = 1'b1;
    else if (is_halt)
      do_halt = 1'b1;
    else
      do_step = 1'b1;
  end

  // PC, state and IF/ID register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      ifid_q  <= '0;
    end else begin
      unique case (1'b1)
        do_redirect: begin
          pc_q         <= bus.branch_target;
          state_q      <= RUN;
          ifid_q.valid <= 1'b0;
        end
        do_hold: begin
        end
        do_halt: begin
          state_q <= HALTED;
          ifid_q  <= '{valid:    1'b1,
                       pc:       pc_q,
                       pc_plus1: pc_next_seq,
                       instr:    bus.imem_instr};
        end
        do_step: begin
          pc_q   <= pc_next_seq;
          ifid_q <= '{valid:    1'b1,
                      pc:       pc_q,
                      pc_plus1: pc_next_seq,
                      instr:    bus.imem_instr};
        end
        do_idle: begin
          ifid_q.valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_valid    = ifid_q.valid;
  assign bus.ifid_pc       = ifid_q.pc;
  assign bus.ifid_pc_plus1 = ifid_q.pc_plus1;
  assign bus.ifid_instr    = ifid_q.instr;
  assign bus.halted        = (state_q == HALTED);

endmodule
